// File: rtl/scan_sequencer_pkg.sv
// scan_pkg: shared types and constants for the seven-segment scan sequencer.
//   state_e          : scan FSM phases (BLANK = anodes off, SHOW = digit lit)
//   content_t        : one display image (hex nibbles, point mask, LE mask)
//   *_DEF            : default timing parameters
//   DIGITS_PER_PAGE  : digits sharing the four anodes
//   min1_clog2()     : counter width helper, never narrower than one bit
package scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] hexs;
    logic [7:0]  point;
    logic [7:0]  les;
  } content_t;

  localparam int DIGIT_CYCLES_DEF = 50000;
  localparam int BLANK_CYCLES_DEF = 2000;
  localparam int PAGE_FRAMES_DEF  = 250;
  localparam int DIGITS_PER_PAGE  = 4;

  function automatic int min1_clog2(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if: valid/ready update channel carrying new display content.
//   upd_valid : producer offers content
//   upd_ready : consumer's one-deep pending buffer is empty
//   upd_hexs  : hex nibbles, digit i = bits [4i+3:4i]
//   upd_point : decimal-point mask
//   upd_les   : LE mask
// master = producer (CPU/debug side), slave = scan sequencer.
interface scan_sequencer_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_hexs;
  logic [7:0]  upd_point;
  logic [7:0]  upd_les;

  modport master (output upd_valid, upd_hexs, upd_point, upd_les, input upd_ready);
  modport slave  (input upd_valid, upd_hexs, upd_point, upd_les, output upd_ready);
endinterface

// File: rtl/scan_sequencer_shadow_buf.sv
// scan_shadow_buf: double buffer between the update channel and the scan mux.
//   clk, rst_n : clock, asynchronous active-low reset
//   upd        : update channel (slave side); drives upd_ready
//   apply_i    : frame-boundary strobe; moves pending content to the active image
//   active_o   : active image shown by the scan mux
// A transfer fills the pending slot; the slot is only emptied by apply_i, so the
// active image never changes mid-frame. upd_ready comes straight from a flop.
module scan_shadow_buf
  import scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  scan_sequencer_if.slave  upd,
  input  logic             apply_i,
  output content_t         active_o
);

  logic     pend_q, pend_d;
  content_t pend_data_q, pend_data_d;
  content_t active_q, active_d;
  logic     ready_q;
  logic     xfer;

  assign xfer = upd.upd_valid && ready_q;

  // NOTE: every always_comb output gets its default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    active_d    = active_q;
    if (apply_i && pend_q) begin
      active_d = pend_data_q;
      pend_d   = 1'b0;
    end
    // ready_q implies an empty slot, so a transfer never collides with an
    // apply of older data; on a boundary-cycle transfer it simply waits a frame.
    if (xfer) begin
      pend_d      = 1'b1;
      pend_data_d = {upd.upd_hexs, upd.upd_point, upd.upd_les};
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      // NOTE: data payload registers are reset as well; the active image must
      // read zero during reset, and the pending copy costs nothing extra.
      pend_data_q <= '0;
      active_q    <= '0;
      ready_q     <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      active_q    <= active_d;
      ready_q     <= ~pend_d;
    end
  end

  assign upd.upd_ready = ready_q;
  assign active_o      = active_q;

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: digit/page sequencer for an 8-digit, 4-anode seven-segment mux.
//   clk, rst_n       : clock, asynchronous active-low reset
//   upd              : update channel (slave) for double-buffered display content
//   page_mode        : 0 = manual page (page_sel), 1 = auto-toggle every PAGE_FRAMES
//   page_sel         : manual page request, sampled at frame boundaries
//   hexs/point/les   : active display image
//   scan             : {page, digit[1:0]} index to the scan mux
//   blank            : 1 = downstream forces all anodes off
//   frame_done       : one-cycle pulse after each 4-digit frame
// Build option SCAN_BLANK_EN: when defined each digit is preceded by BLANK_CYCLES
// of all-anodes-off (anti-ghosting); when undefined blank is tied low and each
// digit period is DIGIT_CYCLES.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIGIT_CYCLES = DIGIT_CYCLES_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
  parameter int PAGE_FRAMES  = PAGE_FRAMES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  scan_sequencer_if.slave upd,
  input  logic            page_mode,
  input  logic            page_sel,
  output logic [31:0]     hexs,
  output logic [7:0]      point,
  output logic [7:0]      les,
  output logic [2:0]      scan,
  output logic            blank,
  output logic            frame_done
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = min1_clog2(CNT_MAX);
  localparam int FCNT_W  = min1_clog2(PAGE_FRAMES);

  localparam logic [CNT_W-1:0]  DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [1:0]        LAST_DIGIT = 2'(DIGITS_PER_PAGE - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST  = FCNT_W'(PAGE_FRAMES - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        digit_q, digit_d;
  logic              page_q, page_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              frame_done_q;
  logic              digit_end;   // last SHOW cycle of the current digit
  logic              boundary;    // last SHOW cycle of digit 3
  content_t          active;

`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_e state_q, state_d;
  logic   blank_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    digit_end = 1'b0;
    unique case (state_q)
      BLANK: if (cnt_q == BLANK_LAST) begin
        cnt_d   = '0;
        state_d = SHOW;
      end
      SHOW: if (cnt_q == DIGIT_LAST) begin
        cnt_d     = '0;
        state_d   = BLANK;
        digit_end = 1'b1;
      end
    endcase
  end

  // blank is registered from the next state so it lines up with the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      blank_q <= (state_d == BLANK);
    end
  end

  assign blank = blank_q;
`else
  // No blank phase: the sequencer is permanently in SHOW.
  always_comb begin
    digit_end = (cnt_q == DIGIT_LAST);
    cnt_d     = digit_end ? '0 : cnt_q + CNT_W'(1);
  end

  assign blank = 1'b0;
`endif

  assign boundary = digit_end && (digit_q == LAST_DIGIT);

  // Digit advance and page selection. In manual mode the frame counter is held
  // at zero, so entering auto mode always starts a fresh PAGE_FRAMES count.
  always_comb begin
    digit_d = digit_q;
    page_d  = page_q;
    fcnt_d  = fcnt_q;
    if (digit_end) begin
      digit_d = (digit_q == LAST_DIGIT) ? 2'd0 : digit_q + 2'd1;
    end
    if (boundary) begin
      if (!page_mode) begin
        page_d = page_sel;
        fcnt_d = '0;
      end else if (fcnt_q == FCNT_LAST) begin
        page_d = ~page_q;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      digit_q      <= 2'd0;
      page_q       <= 1'b0;
      fcnt_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      page_q       <= page_d;
      fcnt_q       <= fcnt_d;
      frame_done_q <= boundary;
    end
  end

  scan_shadow_buf u_shadow_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .upd      (upd),
    .apply_i  (boundary),
    .active_o (active)
  );

  assign hexs       = active.hexs;
  assign point      = active.point;
  assign les        = active.les;
  assign scan       = {page_q, digit_q};
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: self-checking bench for scan_sequencer (DIGIT_CYCLES=4,
// BLANK_CYCLES=2, PAGE_FRAMES=2). Works with SCAN_BLANK_EN defined or not.
// Scan timing is derived from the edge count since reset release; accepted
// updates go into a scoreboard tagged with the frame boundary that applies them.
module tb_scan_sequencer;
  import scan_pkg::*;

  localparam int D  = 4;
  localparam int B  = 2;
  localparam int PF = 2;
`ifdef SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  localparam int P = BLANK_EN ? (B + D) : D;   // digit period
  localparam int F = DIGITS_PER_PAGE * P;      // frame period

  typedef struct {
    content_t data;
    int       apply_t;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic        page_mode;
  logic        page_sel;
  logic [31:0] hexs;
  logic [7:0]  point;
  logic [7:0]  les;
  logic [2:0]  scan;
  logic        blank;
  logic        frame_done;

  scan_sequencer_if bus ();

  scan_sequencer #(
    .DIGIT_CYCLES (D),
    .BLANK_CYCLES (B),
    .PAGE_FRAMES  (PF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd        (bus),
    .page_mode  (page_mode),
    .page_sel   (page_sel),
    .hexs       (hexs),
    .point      (point),
    .les        (les),
    .scan       (scan),
    .blank      (blank),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  int       t      = 0;     // rising edges since reset release
  sb_t      sb[$];
  content_t exp_active;
  logic     exp_page;
  int       exp_fcnt;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic logic model_ready();
    return (t > 0) && (sb.size() == 0);
  endfunction

  task automatic reset_model();
    t          = 0;
    sb.delete();
    exp_active = '0;
    exp_page   = 1'b0;
    exp_fcnt   = 0;
  endtask

  task automatic check_outputs();
    logic [1:0] d2;
    logic       exp_blank;
    logic       exp_fd;
    d2        = 2'((t / P) % DIGITS_PER_PAGE);
    exp_blank = BLANK_EN && ((t % P) < B);
    exp_fd    = (t > 0) && ((t % F) == 0);
    check("scan",       48'(scan),          48'({exp_page, d2}));
    check("blank",      48'(blank),         48'(exp_blank));
    check("frame_done", 48'(frame_done),    48'(exp_fd));
    check("upd_ready",  48'(bus.upd_ready), 48'(model_ready()));
    check("content",    {hexs, point, les}, exp_active);
  endtask

  // One clock: update the model at the edge, then sample on the falling edge.
  task automatic cyc();
    logic m;
    logic s;
    sb_t  e;
    m = page_mode;
    s = page_sel;
    @(posedge clk);
    t++;
    if ((t % F) == 0) begin
      if (!m) begin
        exp_page = s;
        exp_fcnt = 0;
      end else if (exp_fcnt == PF - 1) begin
        exp_page = ~exp_page;
        exp_fcnt = 0;
      end else begin
        exp_fcnt++;
      end
    end
    if (sb.size() > 0 && sb[0].apply_t == t) begin
      e          = sb.pop_front();
      exp_active = e.data;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to(input int phase);
    int n;
    n = 0;
    while ((t % F) != phase && n <= F) begin
      cyc();
      n++;
    end
  endtask

  // Hold valid with junk data until the slot is free, then present the real data.
  task automatic send(input content_t c);
    int  n;
    sb_t e;
    n = 0;
    bus.upd_valid = 1'b1;
    while (!model_ready() && n < 4 * F) begin
      bus.upd_hexs  = $urandom;
      bus.upd_point = 8'($urandom);
      bus.upd_les   = 8'($urandom);
      cyc();
      n++;
    end
    checks++;
    assert (model_ready()) else begin
      errors++;
      $error("FAIL send_timeout: waited %0d cycles, required slot free", n);
    end
    {bus.upd_hexs, bus.upd_point, bus.upd_les} = c;
    e.data    = c;
    e.apply_t = ((t + 1) / F + 1) * F;
    sb.push_back(e);
    cyc();
    bus.upd_valid = 1'b0;
    bus.upd_hexs  = $urandom;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    page_mode     = 1'b0;
    page_sel      = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_hexs  = '0;
    bus.upd_point = '0;
    bus.upd_les   = '0;
    reset_model();

    // Reset state, then release; ready rises one clock after release.
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    check_outputs();

    // Basic scan over two frames.
    run(2 * F);

    // Mid-frame update, then a second update held off by back-pressure.
    run_to(F / 2);
    send('{hexs: 32'h89AB_CDEF, point: 8'h5A, les: 8'hC3});
    send('{hexs: 32'h1234_5678, point: 8'hA5, les: 8'h3C});
    run(2 * F);

    // Transfer on the exact boundary cycle: applied one frame later.
    run_to(F - 1);
    send('{hexs: 32'hCAFE_F00D, point: 8'h81, les: 8'h7E});
    run(2 * F);

    // Manual page request mid-frame, then auto-toggle, then back to manual.
    run_to(F / 2);
    page_sel = 1'b1;
    run(2 * F);
    page_mode = 1'b1;
    run(5 * F);
    page_mode = 1'b0;
    page_sel  = 1'b0;
    run(2 * F);

    // Asynchronous reset during SHOW with the pending slot full.
    send('{hexs: 32'hDEAD_BEEF, point: 8'hFF, les: 8'h01});
    while (BLANK_EN && (t % P) < B) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_outputs();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    run(F + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
